riscv_test_monitor: RTL
=======================

RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 Parameter NUM_TEST, default 22, number of expected-result table entries.
REQ-002 Parameter DWIDTH, default 32, width of the observed output port and of the expected answers.
REQ-003 Parameter IDX_W, default 5, table index width; SHALL satisfy 2**IDX_W >= NUM_TEST.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000, watchdog limit in RUN cycles.
REQ-005 CLK  in  1  single clock; all state changes on its rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 CFG_WE  in  1  table write strobe.
REQ-008 CFG_IDX  in  IDX_W  table entry written.
REQ-009 CFG_NUM_INST  in  32  retired-instruction count at which the entry is checked.
REQ-010 CFG_ANS  in  DWIDTH  expected OUTPUT_PORT value.
REQ-011 START  in  1  begin or restart a run.
REQ-012 NUM_INST  in  32  retired-instruction count from the core.
REQ-013 OUTPUT_PORT  in  DWIDTH  observed core output.
REQ-014 HALT  in  1  core halt indication.
REQ-015 STATE  out  3  IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
REQ-016 DONE  out  1  high while STATE is PASS, FAIL or TIMEOUT.
REQ-017 PASS_CNT  out  IDX_W+1  number of entries passed in the current run.
REQ-018 FAIL_CODE  out  2  0=none, 1=mismatch, 2=missing (halted before the entry was checked).
REQ-019 FAIL_IDX / FAIL_DATA  out  IDX_W / DWIDTH  failing entry index and the OUTPUT_PORT value captured for it.
REQ-020 CYCLE  out  32  number of rising edges spent in RUN.

Function
REQ-021 Table: NUM_TEST entries, each {valid, num_inst, ans, passed}.
  - CFG_WE writes the entry and sets valid in IDLE or any terminal state.
  - CFG_WE is ignored in RUN, and ignored when CFG_IDX >= NUM_TEST.
REQ-022 START in IDLE or a terminal state SHALL, at the next edge:
  - enter RUN;
  - clear all passed bits, PASS_CNT, CYCLE, FAIL_CODE, FAIL_IDX and FAIL_DATA;
  - keep table contents.
  START is ignored in RUN.
REQ-023 Check in RUN, on each edge, for every valid, unpassed entry with num_inst == NUM_INST:
  - OUTPUT_PORT == ans: set passed and increment PASS_CNT; several entries passing in one cycle each add 1.
  - Otherwise: the entry fails.
REQ-024 Failure capture in a cycle with one or more failing entries:
  - next STATE=FAIL, FAIL_CODE=1;
  - FAIL_IDX = lowest failing index, FAIL_DATA = OUTPUT_PORT;
  - passing entries in the same cycle are still counted.
REQ-025 HALT in RUN with no mismatch in the same cycle:
  - all valid entries passed (including passes made this cycle): next STATE=PASS;
  - otherwise: STATE=FAIL, FAIL_CODE=2, FAIL_IDX = lowest valid unpassed index, FAIL_DATA = OUTPUT_PORT.
REQ-026 Same-cycle priority: mismatch > HALT.
REQ-027 Latency: results are visible on outputs one edge after the inputs are sampled; no combinational path from inputs to outputs.
REQ-028 Counters:
  - CYCLE increments on every RUN edge and saturates at 2**32-1;
  - NUM_INST wrap-around is not special-cased; equality compare only.
REQ-029 Terminal states hold all outputs until START or RST.
REQ-030 A run with zero valid entries SHALL reach PASS on HALT.

Reset
REQ-031 RST asserted, including mid-run, SHALL immediately:
  - set STATE=IDLE;
  - set DONE, PASS_CNT, FAIL_CODE, FAIL_IDX, FAIL_DATA and CYCLE to 0;
  - clear all valid and passed bits.
  Table num_inst/ans contents are don't-care after reset.
REQ-032 Inputs are ignored while RST is high; first action possible at the first edge after deassertion.

Configuration
REQ-033 Macro TEST_MON_TIMEOUT_EN controls the watchdog.
  - Defined: a RUN cycle in which CYCLE == TIMEOUT_CYCLES-1 and no FAIL/PASS transition occurs SHALL move STATE to TIMEOUT, FAIL_CODE unchanged.
  - Not defined: no watchdog logic is built, TIMEOUT is unreachable, and RUN persists until HALT or mismatch.

Verification
REQ-034 Load 3 entries {1:5, 2:0, 3:1}, START, drive NUM_INST 1,2,3 with matching outputs, then HALT -> PASS_CNT=3, STATE=PASS, DONE=1.
REQ-035 Entry 4 expects 0x0F, NUM_INST=4 with OUTPUT_PORT=0x0E -> STATE=FAIL, FAIL_CODE=1, FAIL_IDX=4, FAIL_DATA=0x0E one edge later.
REQ-036 Entries 0 and 1 both at num_inst 7 (ans 2, ans 3), OUTPUT_PORT=3 with HALT in the same cycle -> FAIL, FAIL_CODE=1, FAIL_IDX=0, PASS_CNT=1.
REQ-037 5 valid entries, HALT after 3 pass -> FAIL, FAIL_CODE=2, FAIL_IDX=3.
REQ-038 TEST_MON_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no HALT -> STATE=TIMEOUT after 16 RUN edges with CYCLE=16; macro undefined -> still RUN at cycle 100.
REQ-039 RST pulsed mid-run after 2 passes -> STATE=IDLE and PASS_CNT=0 immediately; START without reload then HALT -> PASS.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// Compares a core's OUTPUT_PORT against a table of expected answers keyed by retired-instruction count.
// Optional run watchdog: define TEST_MON_TIMEOUT_EN to build it.
module riscv_test_monitor #(
  parameter int NUM_TEST       = 22,
  parameter int DWIDTH         = 32,
  parameter int IDX_W          = 5,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CFG_WE,
  input  logic [IDX_W-1:0]  CFG_IDX,
  input  logic [31:0]       CFG_NUM_INST,
  input  logic [DWIDTH-1:0] CFG_ANS,
  input  logic              START,
  input  logic [31:0]       NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic [2:0]        STATE,
  output logic              DONE,
  output logic [IDX_W:0]    PASS_CNT,
  output logic [1:0]        FAIL_CODE,
  output logic [IDX_W-1:0]  FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_DATA,
  output logic [31:0]       CYCLE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_MISSING  = 2'd2;

  if ((2 ** IDX_W) < NUM_TEST) begin : g_idx_w_check
    $error("IDX_W is too narrow to address NUM_TEST entries");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef TEST_MON_TIMEOUT_EN
  localparam logic [31:0] LP_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
`endif

  state_t              r_state;
  logic                r_done;
  logic [NUM_TEST-1:0] r_valid;
  logic [NUM_TEST-1:0] r_passed;
  logic [31:0]         r_num_inst [NUM_TEST];
  logic [DWIDTH-1:0]   r_ans      [NUM_TEST];
  logic [IDX_W:0]      r_pass_cnt;
  logic [1:0]          r_fail_code;
  logic [IDX_W-1:0]    r_fail_idx;
  logic [DWIDTH-1:0]   r_fail_data;
  logic [31:0]         r_cycle;

  logic                w_run;
  logic [NUM_TEST-1:0] w_cfg_sel;
  logic [NUM_TEST-1:0] w_hit;
  logic [NUM_TEST-1:0] w_pass_vec;
  logic [NUM_TEST-1:0] w_fail_vec;
  logic [IDX_W:0]      w_pass_add;
  logic                w_any_fail;
  logic                w_all_passed;
  logic [IDX_W-1:0]    w_fail_idx;
  logic [IDX_W-1:0]    w_miss_idx;

  // Table writes are accepted only outside RUN; an out-of-range CFG_IDX selects no entry.
  always_comb begin
    w_run     = (r_state == S_RUN);
    w_cfg_sel = '0;
    for (int i = 0; i < NUM_TEST; i++) begin
      w_cfg_sel[i] = CFG_WE && !w_run && (CFG_IDX == IDX_W'(i));
    end
  end

  // Walking downwards leaves the lowest matching index in the index results.
  always_comb begin
    w_hit        = '0;
    w_pass_vec   = '0;
    w_fail_vec   = '0;
    w_pass_add   = '0;
    w_any_fail   = 1'b0;
    w_all_passed = 1'b1;
    w_fail_idx   = '0;
    w_miss_idx   = '0;
    for (int i = NUM_TEST - 1; i >= 0; i--) begin
      w_hit[i]      = r_valid[i] && !r_passed[i] && (r_num_inst[i] == NUM_INST);
      w_pass_vec[i] = w_hit[i] && (r_ans[i] == OUTPUT_PORT);
      w_fail_vec[i] = w_hit[i] && !w_pass_vec[i];
      w_pass_add    = w_pass_add + (IDX_W + 1)'(w_pass_vec[i]);
      if (w_fail_vec[i]) begin
        w_any_fail = 1'b1;
        w_fail_idx = IDX_W'(i);
      end
      if (r_valid[i] && !r_passed[i] && !w_pass_vec[i]) begin
        w_all_passed = 1'b0;
        w_miss_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_TEST; i++) begin
      if (w_cfg_sel[i] && !RST) begin
        r_num_inst[i] <= CFG_NUM_INST;
        r_ans[i]      <= CFG_ANS;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_valid     <= '0;
      r_passed    <= '0;
      r_pass_cnt  <= '0;
      r_fail_code <= FC_NONE;
      r_fail_idx  <= '0;
      r_fail_data <= '0;
      r_cycle     <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_cycle != '1) begin
            r_cycle <= r_cycle + 32'd1;
          end
          r_passed   <= r_passed | w_pass_vec;
          r_pass_cnt <= r_pass_cnt + w_pass_add;
          if (w_any_fail) begin
            r_state     <= S_FAIL;
            r_done      <= 1'b1;
            r_fail_code <= FC_MISMATCH;
            r_fail_idx  <= w_fail_idx;
            r_fail_data <= OUTPUT_PORT;
          end else if (HALT) begin
            r_done <= 1'b1;
            if (w_all_passed) begin
              r_state <= S_PASS;
            end else begin
              r_state     <= S_FAIL;
              r_fail_code <= FC_MISSING;
              r_fail_idx  <= w_miss_idx;
              r_fail_data <= OUTPUT_PORT;
            end
          end
`ifdef TEST_MON_TIMEOUT_EN
          else if (r_cycle == LP_TIMEOUT_LAST) begin
            r_state <= S_TIMEOUT;
            r_done  <= 1'b1;
          end
`endif
        end
        default: begin
          r_valid <= r_valid | w_cfg_sel;
          if (START) begin
            r_state     <= S_RUN;
            r_done      <= 1'b0;
            r_passed    <= '0;
            r_pass_cnt  <= '0;
            r_fail_code <= FC_NONE;
            r_fail_idx  <= '0;
            r_fail_data <= '0;
            r_cycle     <= '0;
          end
        end
      endcase
    end
  end

  assign STATE     = r_state;
  assign DONE      = r_done;
  assign PASS_CNT  = r_pass_cnt;
  assign FAIL_CODE = r_fail_code;
  assign FAIL_IDX  = r_fail_idx;
  assign FAIL_DATA = r_fail_data;
  assign CYCLE     = r_cycle;

endmodule
